// File: rtl/mig_ctrl_pkg.sv
// ============================================================================
// mig_ctrl_pkg : shared MIG user-interface widths, commands and read FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package mig_ctrl_pkg;

    localparam int         MIG_ADDR_W    = 28;
    localparam int         MIG_DATA_W    = 128;
    localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
    localparam logic [2:0] MIG_CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_CMD  = 2'd1,
        RD_WAIT = 2'd2
    } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/mig_ctrl_rd.sv
// ============================================================================
// mig_ctrl_rd : burst-read controller for the MIG user interface
// Rev 1.0
// ============================================================================
`default_nettype none

module mig_ctrl_rd
    import mig_ctrl_pkg::*;
#(
    parameter int ADDR_STEP       = 8,
    parameter int MAX_OUTSTANDING = 32
) (
    input  logic                  ui_clk,
    input  logic                  rst_n,
    input  logic                  rd_req,
    input  logic [MIG_ADDR_W-1:0] rd_req_addr,
    input  logic [15:0]           rd_length,
    output logic                  rd_busy,
    output logic [MIG_DATA_W-1:0] rd_data,
    output logic                  rd_data_valid,
    output logic                  rd_done,
    output logic [MIG_ADDR_W-1:0] app_rd_addr,
    output logic [2:0]            app_rd_cmd,
    output logic                  app_rd_en,
    input  logic                  app_rdy,
    input  logic [MIG_DATA_W-1:0] app_rd_data,
    input  logic                  app_rd_data_valid,
    input  logic                  app_rd_data_end
);

    localparam logic [7:0]            c_MAX_OUT   = 8'(MAX_OUTSTANDING);
    localparam logic [MIG_ADDR_W-1:0] c_ADDR_STEP = MIG_ADDR_W'(ADDR_STEP);

    rd_state_e             r_state;
    rd_state_e             w_state_next;
    logic [MIG_ADDR_W-1:0] r_addr;
    logic [15:0]           r_len;
    logic [15:0]           r_cmd_cnt;
    logic [15:0]           r_beat_cnt;
    logic [7:0]            r_out;
    logic                  r_busy;
    logic                  r_data_valid;
    logic                  r_done;
    logic [MIG_DATA_W-1:0] r_data;

    logic        w_start;
    logic        w_en;
    logic        w_accept;
    logic        w_beat;
    logic        w_last_beat;
    logic [15:0] w_len_m1;
    logic        w_unused;

    assign w_len_m1    = r_len - 16'd1;
    assign w_accept    = w_en && app_rdy;
    assign w_beat      = app_rd_data_valid && (r_state != RD_IDLE);
    assign w_last_beat = w_beat && (r_beat_cnt == w_len_m1);
    assign w_unused    = app_rd_data_end;

    // A new request is held off while rd_busy still covers the cycle after rd_done.
    always_comb begin
        w_state_next = r_state;
        w_en         = 1'b0;
        w_start      = 1'b0;
        case (r_state)
            RD_IDLE: begin
                if (rd_req && (rd_length != 16'd0) && !r_busy) begin
                    w_start      = 1'b1;
                    w_state_next = RD_CMD;
                end
            end
            RD_CMD: begin
                w_en = (r_out < c_MAX_OUT);
                if (w_en && app_rdy && (r_cmd_cnt == w_len_m1)) begin
                    w_state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                w_en = 1'b0;
            end
            default: begin
                w_state_next = RD_IDLE;
            end
        endcase
        if (w_last_beat) begin
            w_state_next = RD_IDLE;
        end
    end

    always_ff @(posedge ui_clk) begin
        if (!rst_n) begin
            r_state      <= RD_IDLE;
            r_addr       <= '0;
            r_len        <= '0;
            r_cmd_cnt    <= '0;
            r_beat_cnt   <= '0;
            r_out        <= '0;
            r_busy       <= 1'b0;
            r_data_valid <= 1'b0;
            r_done       <= 1'b0;
            r_data       <= '0;
        end else begin
            r_state      <= w_state_next;
            r_busy       <= w_start || (r_state != RD_IDLE);
            r_data_valid <= w_beat;
            r_done       <= w_last_beat;
            if (w_beat) begin
                r_data <= app_rd_data;
            end
            if (w_start) begin
                r_addr     <= rd_req_addr;
                r_len      <= rd_length;
                r_cmd_cnt  <= '0;
                r_beat_cnt <= '0;
                r_out      <= '0;
            end else begin
                if (w_accept) begin
                    r_addr    <= r_addr + c_ADDR_STEP;
                    r_cmd_cnt <= r_cmd_cnt + 16'd1;
                end
                if (w_beat) begin
                    r_beat_cnt <= r_beat_cnt + 16'd1;
                end
                case ({w_accept, w_beat})
                    2'b10:   r_out <= r_out + 8'd1;
                    2'b01:   r_out <= r_out - 8'd1;
                    default: r_out <= r_out;
                endcase
            end
        end
    end

    assign rd_busy       = r_busy;
    assign rd_data       = r_data;
    assign rd_data_valid = r_data_valid;
    assign rd_done       = r_done;
    assign app_rd_addr   = r_addr;
    assign app_rd_cmd    = MIG_CMD_READ;
    assign app_rd_en     = w_en;

endmodule

`default_nettype wire

// File: doc/mig_ctrl_rd.md
# mig_ctrl_rd

Read-side controller between user logic and the MIG user interface, companion to the MIG write controller on the same `ui_clk` domain. It accepts one burst-read request (start address, length in 128-bit beats), issues `rd_length` read commands with the address stepping by 8 per command (4:1 clock ratio, BL8), and counts returned beats. Returned data is delivered to the user side through one register stage, and `rd_done` pulses on the last beat. An outstanding-command limit prevents over-issuing, because MIG read data cannot be back-pressured.

## Interface
- `ADDR_STEP`, default 8: address increment per accepted read command.
- `MAX_OUTSTANDING`, default 32: maximum commands accepted but not yet returned; range 1..255.
- `ui_clk`  in  1  MIG user clock; the only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `rd_req`  in  1  start request; sampled only in IDLE.
- `rd_req_addr`  in  28  start address; captured with `rd_req`.
- `rd_length`  in  16  number of 128-bit beats; captured with `rd_req`.
- `rd_busy`  out  1  high from the cycle after acceptance until the cycle after `rd_done`.
- `rd_data`  out  128  registered read data.
- `rd_data_valid`  out  1  `rd_data` is valid this cycle.
- `rd_done`  out  1  one-cycle pulse, coincident with the final `rd_data_valid`.
- `app_rd_addr`  out  28  command address.
- `app_rd_cmd`  out  3  constant 3'b001 (read).
- `app_rd_en`  out  1  command request.
- `app_rdy`  in  1  MIG command ready.
- `app_rd_data`  in  128  MIG read data.
- `app_rd_data_valid`  in  1  MIG read data valid.
- `app_rd_data_end`  in  1  MIG end of burst; not used for counting.

## Operation
- States are IDLE, CMD, WAIT.
- **IDLE**
  - If `rd_req && rd_length != 0`: capture the address into the command-address register and the length into `len_r`, clear the counters, go to CMD.
  - If `rd_length == 0`: ignore the request; no busy, no done.
- **CMD**
  - `app_rd_en = (outstanding < MAX_OUTSTANDING)`.
  - A command is accepted when `app_rd_en && app_rdy`. On acceptance: `cmd_cnt` increments and the address increments by `ADDR_STEP`, wrapping modulo 2^28.
  - When the accepted command is number `len_r - 1`, go to WAIT.
- **WAIT**
  - `app_rd_en = 0`.
  - Stay in WAIT until the last beat returns, then go to IDLE.
- **Beat counting**
  - A beat arrives when `app_rd_data_valid` is high and the state is not IDLE. On each beat, `beat_cnt` increments.
  - The last beat is `beat_cnt == len_r - 1` together with a beat arrival.
  - The last beat forces IDLE from either CMD or WAIT. This is defensive only; in normal operation data cannot precede its command.
- **Outstanding counter** (8 bits)
  - +1 on command acceptance, −1 on beat arrival, unchanged when both occur in the same cycle.
- `app_rd_data_valid` while in IDLE (stale data after reset or a spurious beat) is dropped: no `rd_data_valid`.
- `rd_req` while busy is ignored and not queued.
- Counters are 16-bit. `rd_length = 65535` is legal and must not overflow.

## Timing
- **Reset values:** state IDLE, `app_rd_en = 0`, `app_rd_addr = 0`, `rd_busy = 0`, `rd_data_valid = 0`, `rd_data = 0`, `rd_done = 0`, all counters 0.
- **Request:** `rd_req` at cycle t (IDLE) gives `rd_busy = 1` and `app_rd_en = 1` at t+1, with `app_rd_addr = rd_req_addr`.
- **Commands:** one command per cycle at most. Back-to-back acceptance runs at full rate while `app_rdy` is high. `app_rd_en` holds, and the address is stable, while `app_rdy` is low.
- **Data path:**
  - `app_rd_data_valid` at cycle c gives `rd_data_valid` at c+1, with `rd_data` equal to the value of `app_rd_data` at c.
  - `rd_done` is asserted at c+1 for the last beat.
  - `rd_busy` falls at c+2; the state is IDLE at c+1, and `rd_busy` is registered.
- **Next request:** a new `rd_req` is accepted at the earliest in the cycle `rd_busy` is low.
- **Throttling:** when outstanding reaches `MAX_OUTSTANDING`, `app_rd_en` deasserts in the next cycle. It re-asserts in the cycle after a beat reduces the count.
- **Reset mid-operation:** synchronous return to reset values at the next edge. Beats still in flight are dropped as IDLE beats.

## Structure
- Shared package `mig_ctrl_pkg` holds the following, so the write and read controllers use the same values:
  - `MIG_ADDR_W = 28`
  - `MIG_DATA_W = 128`
  - `MIG_CMD_WRITE = 3'b000`
  - `MIG_CMD_READ = 3'b001`
  - the state enum for this block
- No sub-module: the FSM, the three counters and the output register stage stay in one module (about 150–200 lines).

## Test plan
- **Single beat:** `rd_req`, addr 0x100, len 1, `app_rdy = 1`, data returned 5 cycles later → one command at addr 0x100; `rd_data_valid` and `rd_done` together; `rd_busy` low 1 cycle later.
- **Burst with stalls:** len 16, addr 0x0, `app_rdy` toggling 1-0 → exactly 16 commands at addresses 0x00..0x78 in steps of 8; address held during stalls; 16 `rd_data_valid`; `rd_done` only on the 16th.
- **Throttle:** `MAX_OUTSTANDING = 4`, len 10, data returned 20 cycles after each command → `app_rd_en` drops after 4 acceptances; never more than 4 outstanding; all 10 beats delivered.
- **Edge cases:**
  - len 0 → no busy, no commands.
  - `rd_req` during busy → ignored; the command count is still the original length.
  - addr 0xFFFFFF8, len 2 → second command at 0x0000000 (wrap).
- **Reset mid-burst:** `rst_n` low after 3 of 8 commands, remaining beats still arrive → all outputs at reset values; no `rd_data_valid` or `rd_done` from the stale beats; a fresh request afterwards completes normally.
- **Simultaneous events:** command acceptance and beat arrival in the same cycle, repeatedly → the outstanding count stays constant; the final counts match the length.
